// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - M-stage load/store to single-outstanding bus bridge
// Optional BUS_TIMEOUT_EN: 8-bit WAIT watchdog that completes the access with BusErr.
module mem_bus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req_M,
  input  logic        WE_M,
  input  logic [31:0] Addr_M,
  input  logic [3:0]  Be_M,
  input  logic [31:0] WData_M,
  output logic        Stall,
  output logic [31:0] RData,
  output logic        RValid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        BusErr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_issue;
  logic        w_timeout;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_unused_addr;

  // Sub-word offset is carried by the byte enables, not the bus address.
  assign w_unused_addr = ^Addr_M[1:0];
  assign RData         = r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    Stall     = 1'b0;
    RValid    = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_be    = 4'd0;
    bus_wdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (Req_M && (Be_M != 4'd0)) begin
          w_issue = 1'b1;
          Stall   = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        Stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = r_we;
        bus_addr  = r_addr;
        bus_be    = r_be;
        bus_wdata = r_wdata;
        if (bus_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        RValid = !r_we;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // State is already IDLE under reset, but Req_M could still raise Stall.
    if (reset) Stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_issue) begin
        r_we    <= WE_M;
        r_addr  <= {Addr_M[31:2], 2'b00};
        r_be    <= Be_M;
        r_wdata <= WData_M;
      end
      if (r_state == S_WAIT && !r_we) begin
        if (bus_ack)        r_rdata <= bus_rdata;
        else if (w_timeout) r_rdata <= 32'd0;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  // The 255th WAIT cycle without ack is the last one; ack in that cycle wins.
  assign w_timeout = (r_state == S_WAIT) && !bus_ack && (r_cnt == 8'd254);
  assign BusErr    = (r_state == S_DONE) && r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      if (w_issue)                                r_cnt <= 8'd0;
      else if (r_state == S_WAIT && !bus_ack)     r_cnt <= r_cnt + 8'd1;
      r_err <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign BusErr    = 1'b0;
`endif

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Req_M  in  1  M-stage memory access valid.
- WE_M  in  1  1 = store, 0 = load.
- Addr_M  in  32  byte address.
- Be_M  in  4  byte enables from the M-stage byte-enable generator.
- WData_M  in  32  store data, already lane-aligned.
- Stall  out  1  freeze pipeline, combinational.
- RData  out  32  registered load word.
- RValid  out  1  one-cycle load-complete pulse.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word-aligned address.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  write data.
- bus_ack  in  1  slave completion.
- bus_rdata  in  32  slave read data, valid with bus_ack.
- BusErr  out  1  timeout pulse.

Function
REQ-002 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-003 In IDLE, when Req_M=1 and Be_M!=0, the block SHALL latch WE_M, {Addr_M[31:2],2'b00}, Be_M and WData_M, and enter WAIT on the next edge.
REQ-004 In IDLE, when Req_M=1 and Be_M==0, the block SHALL start no transaction and SHALL hold Stall at 0.
REQ-005 Stall SHALL equal (IDLE & Req_M & |Be_M) | WAIT.
REQ-006 In WAIT, bus_req SHALL be 1, and bus_we, bus_addr, bus_be and bus_wdata SHALL be driven from the latched values and held stable until acknowledged.
REQ-007 Outside WAIT, bus_req SHALL be 0, and the other bus outputs SHALL be 0.
REQ-008 In WAIT, when bus_ack=1, the block SHALL enter DONE on the next edge and, for a load only, SHALL capture bus_rdata into RData at that edge.
REQ-009 The minimum access SHALL be 3 cycles: IDLE issue, WAIT with ack, DONE.
REQ-010 In DONE, Stall SHALL be 0 and Req_M SHALL be ignored, so the same M-stage instruction is never issued twice; the next state SHALL be IDLE.
REQ-011 RValid SHALL be 1 only in a DONE cycle that follows a load.
REQ-012 RData SHALL hold its value until the next completed load.
REQ-013 A bus_ack received in IDLE or DONE SHALL be ignored.
REQ-014 Stores SHALL leave RData unchanged.

Reset
REQ-015 Reset SHALL act asynchronously and SHALL force state IDLE, RData=0, all latched fields to 0 and the timeout counter to 0.
REQ-016 While reset is held, all outputs SHALL be 0.
REQ-017 A reset asserted during WAIT SHALL abort the access immediately; bus_req SHALL drop without waiting for the clock, and no RValid pulse SHALL follow.

Configuration
REQ-018 When BUS_TIMEOUT_EN is defined, the block SHALL include an 8-bit counter with the following behaviour:
- The counter clears on entry to WAIT and increments each WAIT cycle without bus_ack.
- When the counter reaches 255 with no ack, the next state is DONE, RData is loaded with 0 for a load, and BusErr pulses for exactly the DONE cycle.
- If bus_ack and the limit coincide, bus_ack wins and BusErr stays 0.
REQ-019 When BUS_TIMEOUT_EN is undefined, WAIT SHALL persist until bus_ack, BusErr SHALL be tied to 0, and no counter SHALL be synthesised.

Verification
REQ-020 The bench SHALL cover at least the following directed scenarios:
- Load hit: Req_M=1, WE_M=0, Addr_M=0x00001006, Be_M=4'b1100; ack after 2 WAIT cycles with bus_rdata=0xDEADBEEF -> bus_addr=0x00001004 and bus_be=4'b1100; Stall high 3 cycles; RData=0xDEADBEEF; RValid pulses once in DONE.
- Byte store: WE_M=1, Be_M=4'b0010, WData_M=0x0000AB00; ack in the first WAIT cycle -> bus_we=1 and bus_wdata=0x0000AB00 held stable; RData unchanged; RValid=0.
- Zero enables: Req_M=1, Be_M=4'b0000 -> bus_req never asserts and Stall=0.
- Spurious ack: bus_ack=1 while in IDLE -> no state change and RData unchanged.
- Reset mid-WAIT: assert reset between clock edges -> bus_req and Stall fall immediately; state IDLE; no RValid pulse.
- With BUS_TIMEOUT_EN defined: load with no ack -> after 255 WAIT cycles, DONE with BusErr=1 for one cycle and RData=0; a second run with bus_ack in the 255th cycle -> BusErr=0.
